tlc_phase_scheduler: RTL

Demand-actuated phase scheduler for the four-way intersection, replacing the fixed 4-state rotation.
- Grants green to one approach (E, W, S, N) at a time, using round-robin over vehicle-sensor requests.
- Enforces min/max green, a yellow interval and an all-red clearance.
- Drives the four 2-bit lamp outputs directly.
- Timing advances only on a 1-cycle tick enable from the existing slow-clock/prescaler path.

---
 rtl/tlc_pkg.sv | 34 +++
 rtl/tlc_rr_arbiter.sv | 30 +++
 rtl/tlc_phase_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlc_pkg
// Brief    : Lamp codes, scheduler states and approach indices for the TLC.
// Revision : 1.0 - initial release
// ============================================================================
package tlc_pkg;

  localparam logic [1:0] LIGHT_GO   = 2'b01;
  localparam logic [1:0] LIGHT_STOP = 2'b10;
  localparam logic [1:0] LIGHT_WARN = 2'b11;

  localparam logic [1:0] DIR_E = 2'd0;
  localparam logic [1:0] DIR_W = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_N = 2'd3;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } tlc_state_e;

  // Lamp pattern for all four approaches, indexed by approach number.
  function automatic logic [3:0][1:0] lamps_for(input tlc_state_e st, input logic [1:0] dir);
    logic [3:0][1:0] lamps;
    lamps = {4{LIGHT_STOP}};
    if (st == GREEN)  lamps[dir] = LIGHT_GO;
    if (st == YELLOW) lamps[dir] = LIGHT_WARN;
    return lamps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tlc_rr_arbiter
// Brief    : Rotate-priority picker; scans last+1, last+2, last+3, last.
// Revision : 1.0 - initial release
// ============================================================================
module tlc_rr_arbiter
  import tlc_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant_idx,
  output logic       any_req
);

  logic [1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    grant_idx = last + 2'd1;
    any_req   = |req;
    w_idx     = last;
    for (int k = 4; k >= 1; k--) begin
      w_idx = last + 2'(k);
      if (req[w_idx]) grant_idx = w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlc_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tlc_phase_scheduler
// Brief    : Demand-actuated four-way phase scheduler with min/max green,
//            yellow and all-red clearance. Optional macro TLC_PREEMPT_EN adds
//            emergency-vehicle preemption (preempt, preempt_dir).
// Revision : 1.0 - initial release
// ============================================================================
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
`ifdef TLC_PREEMPT_EN
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
`endif
  output logic [1:0] light_e,
  output logic [1:0] light_w,
  output logic [1:0] light_s,
  output logic [1:0] light_n,
  output logic [1:0] phase,
  output logic       busy_yel
);

  localparam int TW = $clog2(GREEN_MAX + 1);
  localparam logic [TW-1:0] c_gmin_last   = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] c_gmax_last   = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] c_yellow_last = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] c_allred_last = TW'(ALLRED_T - 1);

  tlc_state_e      r_state, w_state_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [1:0]      r_last,  w_last_nxt;
  logic [1:0]      r_phase, w_phase_nxt;
  logic [3:0][1:0] r_lights, w_lights_nxt;
  logic            r_busy,  w_busy_nxt;

  logic [3:0] w_other;
  logic [3:0] w_arb_req;
  logic [1:0] w_grant;
  logic [1:0] w_pick;
  logic       w_arb_any;
  logic       w_leave;

  // One arbiter serves both decisions: in GREEN it only reports whether any
  // other approach is waiting; elsewhere it picks the next grant.
  assign w_other   = req & ~(4'b0001 << r_phase);
  assign w_arb_req = (r_state == GREEN) ? w_other : req;

  tlc_rr_arbiter u_arb (
    .req       (w_arb_req),
    .last      (r_last),
    .grant_idx (w_grant),
    .any_req   (w_arb_any)
  );

  always_comb begin
    w_pick  = w_grant;
    w_leave = (r_timer >= c_gmin_last) && w_arb_any &&
              (!req[r_phase] || (r_timer >= c_gmax_last));
`ifdef TLC_PREEMPT_EN
    if (preempt) begin
      w_pick  = preempt_dir;
      w_leave = (r_phase != preempt_dir);
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_phase_nxt = r_phase;
    w_last_nxt  = r_last;
    if (tick) begin
      case (r_state)
        ALLRED: begin
          if (r_timer == c_allred_last) begin
            w_state_nxt = GREEN;
            w_timer_nxt = '0;
            w_phase_nxt = w_pick;
            w_last_nxt  = w_pick;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        GREEN: begin
          if (w_leave) begin
            w_state_nxt = YELLOW;
            w_timer_nxt = '0;
          end else if (r_timer < c_gmax_last) begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        YELLOW: begin
          if (r_timer == c_yellow_last) begin
            w_state_nxt = ALLRED;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        default: begin
          w_state_nxt = ALLRED;
          w_timer_nxt = '0;
        end
      endcase
    end
    w_lights_nxt = lamps_for(w_state_nxt, w_phase_nxt);
    w_busy_nxt   = (w_state_nxt == YELLOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ALLRED;
      r_timer  <= '0;
      r_last   <= DIR_N;
      r_phase  <= DIR_N;
      r_lights <= {4{LIGHT_STOP}};
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_last   <= w_last_nxt;
      r_phase  <= w_phase_nxt;
      r_lights <= w_lights_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign light_e  = r_lights[DIR_E];
  assign light_w  = r_lights[DIR_W];
  assign light_s  = r_lights[DIR_S];
  assign light_n  = r_lights[DIR_N];
  assign phase    = r_phase;
  assign busy_yel = r_busy;

  // GO and WARN both have bit 0 set; STOP does not.
  a_single_go : assert property (@(posedge clk) disable iff (rst)
    $onehot0({light_n[0], light_s[0], light_w[0], light_e[0]}));

endmodule
`default_nettype wire
